// File: rtl/uart_rcv_8n1.sv
// -----------------------------------------------------------------------------
// uart_rcv_8n1
//   UART receiver for a serial 8N1, LSB-first, idle-high line. The receiver
//   delivers one byte per frame together with a sticky rdy flag. The consumer
//   acknowledges the byte by pulsing clr_rdy. A framing error (stop bit
//   sampled low) is reported on frame_err. The byte is still delivered when a
//   framing error occurs.
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   rst_n      in   1  asynchronous active-low reset
//   RX         in   1  asynchronous serial input, idle high
//   clr_rdy    in   1  consumer acknowledge, clears rdy
//   rdy        out  1  byte available in rx_data (sticky)
//   rx_data    out  8  last completed byte, held until the next completed frame
//   frame_err  out  1  last completed frame had its stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rcv_8n1 #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_M1  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECEIVE = 1'b1
  } state_t;

  logic          sync1_q;
  logic          rx_s_q;
  state_t        state_q,     state_d;
  logic [CW-1:0] baud_cnt_q,  baud_cnt_d;
  logic [3:0]    bit_cnt_q,   bit_cnt_d;
  logic [7:0]    shift_q,     shift_d;
  logic [7:0]    rx_data_q,   rx_data_d;
  logic          rdy_q,       rdy_d;
  logic          frame_err_q, frame_err_d;
  logic          start_det_s;
  logic          rdy_set_s;

  // Two-flop synchronizer. Both stages preset high so that the reset state
  // looks like an idle line and does not produce a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX;
      rx_s_q  <= sync1_q;
    end
  end

  // Next-state logic for the receive FSM, the counters, the shift register and the outputs.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    start_det_s = 1'b0;
    rdy_set_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The first sample therefore lands in the middle of the start bit.
        baud_cnt_d = HALF_M1;
        bit_cnt_d  = 4'd0;
        if (!rx_s_q) begin
          start_det_s = 1'b1;
          state_d     = ST_RECEIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RECEIVE: begin
        if (baud_cnt_q == CNT_ZERO) begin
          baud_cnt_d = BAUD_M1;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            // A start bit that is high at mid-bit was a glitch.
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RECEIVE;
            end
          end else if (bit_cnt_q <= 4'd8) begin
            shift_d = {rx_s_q, shift_q[7:1]};
          end else begin
            // Stop-bit sample. The FSM goes back to idle at mid-stop-bit,
            // so a back-to-back start edge is not missed.
            rx_data_d   = shift_q;
            frame_err_d = ~rx_s_q;
            rdy_set_s   = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = HALF_M1;
        bit_cnt_d  = 4'd0;
      end
    endcase

    // Order of precedence: a completed frame sets rdy. A start detect or clr_rdy clears it.
    // A frame cannot complete on the same clock as a start detect.
    if (rdy_set_s) begin
      rdy_d = 1'b1;
    end else if (start_det_s || clr_rdy) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
  end

  // State, counter, shift-register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= CNT_ZERO;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rdy       = rdy_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;

endmodule
